// File: rtl/spi_seq_pkg.sv
// Shared types and helpers for the SPI read job sequencer.
package spi_seq_pkg;

    localparam int MODE_W  = 3;
    localparam int RETRY_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_SETTLE = 3'd2,
        ST_LAUNCH = 3'd3,
        ST_WAIT   = 3'd4,
        ST_NEXT   = 3'd5,
        ST_DONE   = 3'd6
    } seq_state_e;

    // Region index width: clog2 of the table size, never narrower than one bit.
    function automatic int region_idx_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_seq_timer.sv
// Loadable down-counter. expired_o is high during the last counted cycle, so a
// load of N on entry to a state gives a state that lasts exactly N cycles.
module spi_seq_timer #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic         expired_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Reload on request, otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == W'(1));

endmodule

// File: rtl/spi_read_job_sequencer.sv
// Walks a table of flash regions and runs one spi_flash_read job per enabled
// region, with a settle gap before every launch, a per-job timeout and a
// bounded number of retries. Failed regions are reported in fail_map.
//
//  state  | meaning
//  IDLE   | after reset, waiting for run_req, mux parked
//  SELECT | sample region idx: skip, reject bad range, or latch job
//  SETTLE | start flag low for SETTLE_CYCLES before a launch/retry
//  LAUNCH | start flag high, waiting for engine to drop read_finish
//  WAIT   | start flag high, waiting for read_finish to rise
//  NEXT   | advance idx or finish the pass
//  DONE   | pass complete, status held until next run_req
module spi_read_job_sequencer
    import spi_seq_pkg::*;
#(
    parameter int NUM_REGIONS    = 4,
    parameter int ADDR_W         = 32,
    parameter int SETTLE_CYCLES  = 10,
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int MAX_RETRY      = 2
) (
    input  logic                                    system_clk,
    input  logic                                    system_reset_n,
    input  logic                                    run_req,
    input  logic [NUM_REGIONS-1:0]                  region_en,
    input  logic [NUM_REGIONS*ADDR_W-1:0]           region_start_addr,
    input  logic [NUM_REGIONS*ADDR_W-1:0]           region_end_addr,
    input  logic [NUM_REGIONS*MODE_W-1:0]           region_mode,
    input  logic [NUM_REGIONS-1:0]                  region_switch_die,
    input  logic [NUM_REGIONS-1:0]                  region_flash_bmc,
    input  logic                                    eng_read_finish,
    output logic                                    eng_start_flag,
    output logic                                    eng_read_req,
    output logic [ADDR_W-1:0]                       eng_start_addr,
    output logic [ADDR_W-1:0]                       eng_end_addr,
    output logic [MODE_W-1:0]                       eng_mode,
    output logic                                    eng_switch_die_need,
    output logic                                    BMC_SEL,
    output logic                                    PCH_SEL,
    output logic                                    busy,
    output logic                                    completed,
    output logic                                    error,
    output logic [NUM_REGIONS-1:0]                  fail_map,
    output logic [region_idx_w(NUM_REGIONS)-1:0]    cur_region
);

    localparam int IDX_W   = region_idx_w(NUM_REGIONS);
    localparam int TMR_MAX = (TIMEOUT_CYCLES > SETTLE_CYCLES) ? TIMEOUT_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    seq_state_e             state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [RETRY_W-1:0]     retry_q, retry_d;
    logic [NUM_REGIONS-1:0] fail_q, fail_d;
    logic [ADDR_W-1:0]      saddr_q, saddr_d, eaddr_q, eaddr_d;
    logic [MODE_W-1:0]      mode_q, mode_d;
    logic                   die_q, die_d;
    logic                   bmc_q, bmc_d, pch_q, pch_d;
    logic                   flag_q, flag_d;
    logic                   busy_q, busy_d, done_q, done_d, err_q, err_d;

    int unsigned            sel_i;
    logic [ADDR_W-1:0]      sel_start, sel_end;
    logic [MODE_W-1:0]      sel_mode;
    logic                   retry_left;
    logic                   tmr_load, tmr_expired;
    logic [TMR_W-1:0]       tmr_val;

    assign sel_i      = 32'(idx_q);
    assign sel_start  = region_start_addr[sel_i*ADDR_W +: ADDR_W];
    assign sel_end    = region_end_addr[sel_i*ADDR_W +: ADDR_W];
    assign sel_mode   = region_mode[sel_i*MODE_W +: MODE_W];
    assign retry_left = (retry_q < RETRY_W'(MAX_RETRY));

    // Next state, job latches, fail bookkeeping and registered status.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        retry_d = retry_q;
        fail_d  = fail_q;
        saddr_d = saddr_q;
        eaddr_d = eaddr_q;
        mode_d  = mode_q;
        die_d   = die_q;
        bmc_d   = bmc_q;
        pch_d   = pch_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE) begin
                    bmc_d = 1'b1;
                    pch_d = 1'b1;
                end
                if (run_req) begin
                    state_d = ST_SELECT;
                    idx_d   = '0;
                    fail_d  = '0;
                end
            end
            ST_SELECT: begin
                if (!region_en[idx_q]) begin
                    state_d = ST_NEXT;
                end else if (sel_end < sel_start) begin
                    fail_d[idx_q] = 1'b1;
                    state_d       = ST_NEXT;
                end else begin
                    saddr_d = sel_start;
                    eaddr_d = sel_end;
                    mode_d  = sel_mode;
                    die_d   = region_switch_die[idx_q];
                    bmc_d   = region_flash_bmc[idx_q];
                    pch_d   = ~region_flash_bmc[idx_q];
                    retry_d = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (tmr_expired) begin
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH, ST_WAIT: begin
                // A finish seen on the expiry cycle still counts as success.
                if (state_q == ST_WAIT && eng_read_finish) begin
                    state_d = ST_NEXT;
                end else if (tmr_expired) begin
                    if (retry_left) begin
                        retry_d = retry_q + 1'b1;
                        state_d = ST_SETTLE;
                    end else begin
                        fail_d[idx_q] = 1'b1;
                        state_d       = ST_NEXT;
                    end
                end else if (state_q == ST_LAUNCH && !eng_read_finish) begin
                    state_d = ST_WAIT;
                end
            end
            ST_NEXT: begin
                if (idx_q == IDX_W'(NUM_REGIONS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ST_SELECT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        flag_d = (state_d == ST_LAUNCH) || (state_d == ST_WAIT);
        busy_d = (state_q != ST_IDLE) && (state_q != ST_DONE);
        done_d = (state_q == ST_DONE) && (state_d == ST_DONE);
        err_d  = done_d && (|fail_q);
    end

    // Timer is reloaded on entry to SETTLE (gap) and LAUNCH (timeout window).
    always_comb begin
        tmr_load = ((state_d == ST_SETTLE) && (state_q != ST_SETTLE)) ||
                   ((state_d == ST_LAUNCH) && (state_q != ST_LAUNCH));
        tmr_val  = (state_d == ST_LAUNCH) ? TMR_W'(TIMEOUT_CYCLES) : TMR_W'(SETTLE_CYCLES);
    end

    spi_seq_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk_i      (system_clk),
        .rst_ni     (system_reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expired_o  (tmr_expired)
    );

    // State and output registers; reset parks the flash mux on both sides.
    always_ff @(posedge system_clk or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            retry_q <= '0;
            fail_q  <= '0;
            saddr_q <= '0;
            eaddr_q <= '0;
            mode_q  <= '0;
            die_q   <= 1'b0;
            bmc_q   <= 1'b1;
            pch_q   <= 1'b1;
            flag_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            retry_q <= retry_d;
            fail_q  <= fail_d;
            saddr_q <= saddr_d;
            eaddr_q <= eaddr_d;
            mode_q  <= mode_d;
            die_q   <= die_d;
            bmc_q   <= bmc_d;
            pch_q   <= pch_d;
            flag_q  <= flag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign eng_start_flag      = flag_q;
    assign eng_read_req        = flag_q;
    assign eng_start_addr      = saddr_q;
    assign eng_end_addr        = eaddr_q;
    assign eng_mode            = mode_q;
    assign eng_switch_die_need = die_q;
    assign BMC_SEL             = bmc_q;
    assign PCH_SEL             = pch_q;
    assign busy                = busy_q;
    assign completed           = done_q;
    assign error               = err_q;
    assign fail_map            = fail_q;
    assign cur_region          = idx_q;

endmodule
